// File: rtl/button_debouncer.sv
// button_debouncer
// Cleans raw asynchronous push-button pins. Every channel has a 2-flop
// synchronizer followed by a two-state debounce FSM whose state is the
// debounced level. A new level is accepted only after COUNT_MAX consecutive
// synchronized samples that disagree with the current level; any sample that
// agrees with the current level restarts the count.
//
// Output protocol: btn_level_o is the debounced level and is also the FSM
// state (STABLE_0 = 0, STABLE_1 = 1). btn_press_o / btn_release_o are
// registered single-cycle pulses raised in the same cycle that btn_level_o
// changes. There is no handshake: a consumer must sample the pulses on every
// clock. Press and release are never high together on one channel.
module button_debouncer #(
  parameter int WIDTH     = 4,
  parameter int COUNT_MAX = 1000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] btn_raw_i,
  output logic [WIDTH-1:0] btn_level_o,
  output logic [WIDTH-1:0] btn_press_o,
  output logic [WIDTH-1:0] btn_release_o
);

  // Counter holds 0 .. COUNT_MAX-1; acceptance happens on the sample that
  // would take it to COUNT_MAX, so it never wraps.
  localparam int              CNT_W    = $clog2(COUNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

  typedef enum logic {
    STABLE_0 = 1'b0,
    STABLE_1 = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Two-flop metastability synchronizer; only sync2_q is used downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             sample;

    assign sample = sync2_q[i];

    // State, stability counter and pulse registers for this channel.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q   <= STABLE_0;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Next state: count disagreeing samples, accept on the COUNT_MAX-th one,
    // restart the count whenever the sample matches the current level.
    always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        STABLE_0: begin
          if (sample) begin
            if (cnt_q == CNT_LAST) begin
              state_d = STABLE_1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        STABLE_1: begin
          if (!sample) begin
            if (cnt_q == CNT_LAST) begin
              state_d   = STABLE_0;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = STABLE_0;
        end
      endcase
    end

    assign btn_level_o[i]   = (state_q == STABLE_1);
    assign btn_press_o[i]   = press_q;
    assign btn_release_o[i] = release_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
// Directed bench for button_debouncer with WIDTH=4, COUNT_MAX=4.
// The stimulus process drives raw pins / reset and pushes expectations:
//   exp_q  : pulse events {cycle, level, press, release}, popped whenever the
//            DUT shows a non-zero press or release.
//   snap_q : output snapshots {cycle, level, press, release}, compared when
//            the cycle counter reaches the stored cycle.
// A raw change applied after cycle C settles at cycle C+6 (COUNT_MAX+2).
module tb_button_debouncer;

  localparam int W  = 4;
  localparam int CM = 4;
  localparam int EW = 16 + 3 * W;

  logic         clk;
  logic         rst;
  logic [W-1:0] btn_raw;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_press;
  logic [W-1:0] btn_release;

  logic [15:0]   cyc;
  logic          done;
  int            checks;
  int            errors;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] snap_q[$];

  button_debouncer #(
    .WIDTH    (W),
    .COUNT_MAX(CM)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .btn_raw_i    (btn_raw),
    .btn_level_o  (btn_level),
    .btn_press_o  (btn_press),
    .btn_release_o(btn_release)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // Expectations for one accepted transition whose settling starts at cycle c
  task automatic expect_settle(input logic [15:0] c, input logic [W-1:0] old_l,
                               input logic [W-1:0] new_l, input logic [W-1:0] p,
                               input logic [W-1:0] r);
    snap_q.push_back({c + 16'd5, old_l, 4'h0, 4'h0});
    exp_q.push_back({c + 16'd6, new_l, p, r});
    snap_q.push_back({c + 16'd7, new_l, 4'h0, 4'h0});
  endtask

  // Drive a new raw value (caller sits just after a negedge) and let it settle
  task automatic apply(input logic [W-1:0] v, input logic [W-1:0] old_l,
                       input logic [W-1:0] new_l, input logic [W-1:0] p,
                       input logic [W-1:0] r);
    btn_raw = v;
    expect_settle(cyc, old_l, new_l, p, r);
    repeat (10) @(negedge clk);
  endtask

  task automatic hold(input logic [W-1:0] v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    checks  = 0;
    errors  = 0;
    done    = 1'b0;
    rst     = 1'b1;
    btn_raw = 4'hF;

    // 1: reset held 3 cycles with all buttons pressed, then re-debounce
    snap_q.push_back({16'd1, 4'h0, 4'h0, 4'h0});
    snap_q.push_back({16'd2, 4'h0, 4'h0, 4'h0});
    snap_q.push_back({16'd3, 4'h0, 4'h0, 4'h0});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_settle(cyc, 4'h0, 4'hF, 4'hF, 4'h0);
    repeat (10) @(negedge clk);

    // 4: release of channel 2
    apply(4'hB, 4'hF, 4'hB, 4'h0, 4'h4);

    // 2: clean press on channel 0 (release it first)
    apply(4'hA, 4'hB, 4'hA, 4'h0, 4'h1);
    apply(4'hB, 4'hA, 4'hB, 4'h1, 4'h0);

    // 3: bounce on channel 1 (release it first)
    apply(4'h9, 4'hB, 4'h9, 4'h0, 4'h2);
    hold(4'hB, 3);
    hold(4'h9, 3);
    hold(4'hB, 3);
    hold(4'h9, 3);
    apply(4'hB, 4'h9, 4'hB, 4'h2, 4'h0);

    // 5: channel 0 rises while channel 3 falls
    apply(4'hA, 4'hB, 4'hA, 4'h0, 4'h1);
    apply(4'h3, 4'hA, 4'h3, 4'h1, 4'h8);

    // 6: reset in the middle of a count on channel 0
    apply(4'h0, 4'h3, 4'h0, 4'h0, 4'h3);
    hold(4'h1, 3);
    rst = 1'b1;
    snap_q.push_back({cyc + 16'd1, 4'h0, 4'h0, 4'h0});
    @(negedge clk);
    rst = 1'b0;
    expect_settle(cyc, 4'h0, 4'h1, 4'h1, 4'h0);
    repeat (10) @(negedge clk);

    done = 1'b1;
  end

  // Monitor / scoreboard and final report
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    got = {cyc, btn_level, btn_press, btn_release};

    if (snap_q.size() != 0 && snap_q[0][EW-1:EW-16] == cyc) begin
      exp = snap_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL snapshot cyc=%0d: got level=%h press=%h release=%h, expected level=%h press=%h release=%h",
                 cyc, btn_level, btn_press, btn_release, exp[11:8], exp[7:4], exp[3:0]);
      end
    end

    if ((btn_press | btn_release) != 4'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d: got level=%h press=%h release=%h, expected no pulse",
                 cyc, btn_level, btn_press, btn_release);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL pulse_event: got cyc=%0d level=%h press=%h release=%h, expected cyc=%0d level=%h press=%h release=%h",
                   cyc, btn_level, btn_press, btn_release, exp[EW-1:EW-16], exp[11:8], exp[7:4], exp[3:0]);
        end
      end
    end

    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_pulses: got %0d outstanding events, expected 0", exp_q.size());
      end
      checks++;
      if (snap_q.size() != 0) begin
        errors++;
        $display("FAIL missing_snapshots: got %0d outstanding snapshots, expected 0", snap_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

endmodule
